// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states, ALU/PC selects.
// Also used by the ALU control and the datapath, so keep the encodings stable.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the sequencer (master) and the datapath/memory (slave).
// Opcode and mem_ready flow in; strobes, selects and status flow out.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             halted;
  logic             illegal_seen;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
    output memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
    output halted, illegal_seen, instr_count, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
    input  memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
    input  halted, illegal_seen, instr_count, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decode of the sequencer state to datapath strobes; zero latency.
// mem_ready only gates irwrite/pcwrite in FETCH so a stalled fetch never double-bumps the PC.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = ALUB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUB_IMM_SL2;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      default: begin
        // HALT and unused encodings drive nothing
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: FSM, retired-instruction counter, sticky illegal flag.
// Moore outputs (zero-latency decode); memory wait states stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_t           state;
  state_t           state_nxt;
  logic             retire;
  logic             illegal_hit;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_seen;
  ctrl_t            ctrl;
  ctrl_t            ctrl_gated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      instr_count  <= '0;
      illegal_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (illegal_hit) begin
        illegal_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    illegal_hit = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_HALT:      state_nxt = S_HALT;
          default: begin
            state_nxt   = S_FETCH;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        // Opcode is re-sampled here; anything but a memory op abandons the access
        if (bus.opcode == OP_LW)      state_nxt = S_MEMRD;
        else if (bus.opcode == OP_SW) state_nxt = S_MEMWR;
        else                          state_nxt = S_FETCH;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt = S_RCOMP;
      end
      S_RCOMP, S_BRANCH, S_JUMP: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset holds the state at FETCH, whose memread must not reach the memory
  assign ctrl_gated = rst_n ? ctrl : '0;

  assign bus.pcwrite      = ctrl_gated.pcwrite;
  assign bus.pcwritecond  = ctrl_gated.pcwritecond;
  assign bus.iord         = ctrl_gated.iord;
  assign bus.memread      = ctrl_gated.memread;
  assign bus.memwrite     = ctrl_gated.memwrite;
  assign bus.irwrite      = ctrl_gated.irwrite;
  assign bus.memtoreg     = ctrl_gated.memtoreg;
  assign bus.regdst       = ctrl_gated.regdst;
  assign bus.regwrite     = ctrl_gated.regwrite;
  assign bus.alusrca      = ctrl_gated.alusrca;
  assign bus.alusrcb      = ctrl_gated.alusrcb;
  assign bus.aluop        = ctrl_gated.aluop;
  assign bus.pcsource     = ctrl_gated.pcsource;
  assign bus.halted       = rst_n && (state == S_HALT);
  assign bus.illegal_seen = illegal_seen;
  assign bus.instr_count  = instr_count;
  assign bus.state_dbg    = state;

endmodule
